// File: rtl/wts_i2s_tx.sv
// wts_i2s_tx: Philips I2S serialiser for the 15-bit offset-binary wave table outputs.
// Serial clocks come from a programmable system-clock divider; outputs change only on BCLK fall events.
module wts_i2s_tx #(
    parameter int BCLK_HALF = 6
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        enable,
    input  logic        mute,
    input  logic [14:0] wavl,
    input  logic [14:0] wavr,
    output logic        sample_ack,
    output logic        i2s_bclk,
    output logic        i2s_lrck,
    output logic        i2s_sdata
);
    logic [7:0]  div_q, div_d;
    logic [4:0]  bit_q, bit_d, bit_nx;
    logic [31:0] shreg_q, shreg_d;
    logic        bclk_q, bclk_d, lrck_q, lrck_d, sdata_q, sdata_d, ack_q, ack_d;
    logic        tc, fall, load;
    logic [15:0] pcm_l, pcm_r;

    always_comb begin
        tc      = div_q == 8'(BCLK_HALF - 1);
        fall    = tc & bclk_q;
        bit_nx  = bit_q + 5'd1;
        load    = fall & (bit_nx == 5'd1);
        pcm_l   = mute ? 16'h0000 : {~wavl[14], wavl[13:0], 1'b0};
        pcm_r   = mute ? 16'h0000 : {~wavr[14], wavr[13:0], 1'b0};
        div_d   = tc ? 8'd0 : div_q + 8'd1;
        bclk_d  = bclk_q ^ tc;
        bit_d   = fall ? bit_nx : bit_q;
        lrck_d  = fall ? bit_nx[4] : lrck_q;
        shreg_d = load ? {pcm_l, pcm_r} : fall ? {shreg_q[30:0], 1'b0} : shreg_q;
        sdata_d = fall ? shreg_d[31] : sdata_q;
        ack_d   = load;
        // Disable is a synchronous clear and overrides a coincident terminal count.
        if (!enable) begin
            div_d   = 8'd0;
            bclk_d  = 1'b0;
            bit_d   = 5'd0;
            lrck_d  = 1'b0;
            shreg_d = 32'd0;
            sdata_d = 1'b0;
            ack_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            div_q   <= 8'd0;
            bclk_q  <= 1'b0;
            bit_q   <= 5'd0;
            lrck_q  <= 1'b0;
            shreg_q <= 32'd0;
            sdata_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            div_q   <= div_d;
            bclk_q  <= bclk_d;
            bit_q   <= bit_d;
            lrck_q  <= lrck_d;
            shreg_q <= shreg_d;
            sdata_q <= sdata_d;
            ack_q   <= ack_d;
        end
    end

    assign sample_ack = ack_q;
    assign i2s_bclk   = bclk_q;
    assign i2s_lrck   = lrck_q;
    assign i2s_sdata  = sdata_q;
endmodule

// File: tb/tb_wts_i2s_tx.sv
// tb_wts_i2s_tx: randomized self-checking bench for wts_i2s_tx against a frame-timing reference model.
module tb_wts_i2s_tx;
    localparam int H = 2;

    logic        clk = 1'b0, nreset = 1'b0, enable = 1'b0, mute = 1'b0;
    logic [14:0] wavl = 15'h7FFF, wavr = 15'h0000;
    logic        sample_ack, i2s_bclk, i2s_lrck, i2s_sdata;

    int          n_chk = 0, n_fail = 0;
    int          n = 0, cap_n = 0, s;
    logic [31:0] mw = '0, cap = '0, frame_cap = '0, w;
    logic        mload = 1'b0, pb = 1'b0, eb, cap_on = 1'b0, frame_rdy = 1'b0, rnd = 1'b0;

    wts_i2s_tx #(.BCLK_HALF(H)) dut (
        .clk(clk), .nreset(nreset), .enable(enable), .mute(mute),
        .wavl(wavl), .wavr(wavr), .sample_ack(sample_ack),
        .i2s_bclk(i2s_bclk), .i2s_lrck(i2s_lrck), .i2s_sdata(i2s_sdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] conv(input logic [14:0] x);
        conv = 16'(int'(x) * 2 - 32768);
    endfunction

    task automatic model_reset();
        n = 0; mw = '0; mload = 1'b0; cap_on = 1'b0; pb = 1'b0;
    endtask

    // Reference: n counts enabled clk edges; BCLK, slot and word position follow from n alone.
    task automatic tick();
        @(posedge clk);
        if (!nreset || !enable) model_reset();
        else begin
            n++;
            mload = (n % (2 * H) == 0) && ((n / (2 * H)) % 32 == 1);
            if (mload) mw = mute ? 32'd0 : {conv(wavl), conv(wavr)};
        end
        eb = ((n / H) % 2) == 1;
        s  = (n / (2 * H)) % 32;
        #1;
        check("bclk", 32'(i2s_bclk), 32'(eb));
        check("lrck", 32'(i2s_lrck), 32'(s >= 16));
        check("sdata", 32'(i2s_sdata), 32'(s == 0 ? mw[0] : mw[32 - s]));
        check("ack", 32'(sample_ack), 32'(mload));
        if (mload) begin
            cap_on = 1'b1; cap_n = 0;
        end else if (eb && !pb && cap_on) begin
            cap = {cap[30:0], i2s_sdata};
            cap_n++;
            if (cap_n == 32) begin
                frame_cap = cap; frame_rdy = 1'b1; cap_on = 1'b0;
            end
        end
        pb = eb;
        if (rnd) wavl = 15'($urandom);
    endtask

    task automatic wait_frame(output logic [31:0] f);
        int t = 0;
        frame_rdy = 1'b0;
        while (!frame_rdy && t < 3 * 64 * H + 10) begin tick(); t++; end
        check("frame_wait", 32'(frame_rdy), 32'd1);
        f = frame_cap;
    endtask

    task automatic first_ack(input string tag);
        int t = 0;
        do begin tick(); t++; end while (!sample_ack && t < 50);
        check(tag, t, 2 * H);
    endtask

    task automatic wait_ack();
        int t = 0;
        do begin tick(); t++; end while (!sample_ack && t < 70 * H);
        check("ack_wait", 32'(sample_ack), 32'd1);
    endtask

    initial begin
        int hi, acks, t;
        #12;
        check("rst_bclk", 32'(i2s_bclk), 32'd0);
        check("rst_lrck", 32'(i2s_lrck), 32'd0);
        check("rst_sdata", 32'(i2s_sdata), 32'd0);
        check("rst_ack", 32'(sample_ack), 32'd0);
        nreset = 1'b1; enable = 1'b1;

        first_ack("first_ack");
        wait_frame(w);
        check("frame_7fff", w, 32'h7FFE8000);
        hi = 0; acks = 0;
        repeat (64 * H) begin tick(); hi += int'(i2s_lrck); acks += int'(sample_ack); end
        check("lrck_high", hi, 32 * H);
        check("ack_per_frame", acks, 1);

        wavl = 15'h4000; wavr = 15'h4000;
        wait_frame(w);
        wait_frame(w);
        check("frame_mid", w, 32'h0);

        mute = 1'b1; wavl = 15'h1234;
        wait_ack();
        repeat (20) tick();
        mute = 1'b0;
        wait_frame(w);
        check("frame_muted", w, 32'h0);
        wait_frame(w);
        check("frame_unmuted", w, 32'hA4680000);

        rnd = 1'b1; wavr = 15'($urandom);
        wait_frame(w);
        repeat (3) begin
            wait_frame(w);
            check("rand_frame", w, mw);
        end
        rnd = 1'b0;

        t = 0;
        while (((n / (2 * H)) % 32 != 20) && t < 70 * H) begin tick(); t++; end
        check("slot20_wait", (n / (2 * H)) % 32, 20);
        enable = 1'b0;
        tick();
        check("dis_bclk", 32'(i2s_bclk), 32'd0);
        check("dis_lrck", 32'(i2s_lrck), 32'd0);
        check("dis_sdata", 32'(i2s_sdata), 32'd0);
        check("dis_ack", 32'(sample_ack), 32'd0);
        repeat (3) tick();
        wavl = 15'h7FFF; wavr = 15'h0000; enable = 1'b1;
        first_ack("reen_first_ack");
        wait_frame(w);
        check("reen_frame", w, 32'h7FFE8000);

        repeat (37) tick();
        #2 nreset = 1'b0;
        #1;
        check("arst_bclk", 32'(i2s_bclk), 32'd0);
        check("arst_lrck", 32'(i2s_lrck), 32'd0);
        check("arst_sdata", 32'(i2s_sdata), 32'd0);
        check("arst_ack", 32'(sample_ack), 32'd0);
        model_reset();
        repeat (3) tick();
        #2 nreset = 1'b1;
        first_ack("arst_first_ack");
        wait_frame(w);
        check("arst_frame", w, 32'h7FFE8000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
